fpu_register_file: RTL and testbench
====================================

# fpu_register_file

Floating-point register file for the F extension: 32 × 32-bit registers `f0`–`f31` plus the `frm` and `fflags` portions of `fcsr`. It is the register-file end of the FPU ↔ register-file channel. It supplies operands to the FPU, accepts FPU results, and accumulates the FPU's exception flags. It also tracks destination registers of in-flight multi-cycle FPU operations, so decode can stall on read-after-write hazards.

## Interface
Parameters
- `NREGS`, 32, number of FP registers (power of two)
- `WIDTH`, 32, register width in bits

Ports
- `clk`  in  1  single clock, rising edge
- `n_rst`  in  1  asynchronous, active-low reset
- `f_rs1`, `f_rs2`  in  5  read addresses
- `f_rs1_data`, `f_rs2_data`  out  WIDTH  read data (combinational)
- `f_rs1_busy`, `f_rs2_busy`  out  1  addressed register has a pending write
- `f_rd`  in  5  write address
- `f_wen`  in  1  write strobe for the FPU result; clears the pending bit of `f_rd`
- `f_w_data`  in  WIDTH  FPU result
- `f_NV`, `f_DZ`, `f_OF`, `f_UF`, `f_NX`  in  1  exception flags accompanying the result; sampled only when `f_wen`=1
- `f_issue`  in  1  FP op issued to FPU; marks `f_issue_rd` pending
- `f_issue_rd`  in  5  destination of issued op
- `f_frm_wen`  in  1  CSR write of `frm`
- `f_frm_in`  in  3  new rounding mode
- `f_frm_out`  out  3  current `frm`
- `f_flags_wen`  in  1  CSR write of `fflags`
- `f_flags_wdata`  in  5  new `fflags` as {NV,DZ,OF,UF,NX}
- `f_flags`  out  5  sticky `fflags` as {NV,DZ,OF,UF,NX}

## Operation
- **Reset.** When `n_rst`=0, asynchronously:
  - all registers are 0;
  - `frm` = 3'b000 (RNE);
  - `fflags` = 5'b0;
  - all pending bits are 0.
- **Register file.** `f0` is an ordinary register and is not hardwired to zero.
- **Reads.**
  - `f_rsN_data` = reg[`f_rsN`].
  - If `f_wen`=1 and `f_rd`=`f_rsN` in the same cycle, `f_rsN_data` = `f_w_data` (write-through bypass).
- **Writes.** When `f_wen`=1, reg[`f_rd`] ← `f_w_data` at the clock edge.
- **Pending bits.** One bit per register.
  - `f_issue` sets pend[`f_issue_rd`].
  - `f_wen` clears pend[`f_rd`].
  - If both target the same register in the same cycle, set wins: the new issue is still outstanding.
  - `f_rsN_busy` = pend[`f_rsN`] & ~(`f_wen` & `f_rd`=`f_rsN`), i.e. the write completing this cycle resolves the hazard.
- **fflags.** fflags_next = (`f_flags_wen` ? `f_flags_wdata` : fflags) | (`f_wen` ? {NV,DZ,OF,UF,NX} : 0).
  - Flags are sticky and clear only by CSR write or reset.
  - On simultaneous CSR write and FPU write, the CSR value is loaded and the new FPU flags are OR-ed in.
- **frm.** When `f_frm_wen`=1, `frm` ← `f_frm_in` only if `f_frm_in` ∈ {000,001,010,011,100}. Reserved values 101, 110 and 111 are ignored and `frm` holds.

## Timing
- Read latency is 0 cycles: combinational from address to data.
- Write, pending-bit, `frm` and `fflags` updates are visible on the first edge after the strobe.
- `f_flags` and `f_frm_out` are direct register outputs with no combinational path from the inputs.
- `f_rsN_busy` is combinational from addresses, pend, `f_wen` and `f_rd`.
- An issue and a read of the same register in the same cycle do not report busy until the next cycle. Decode owns that same-cycle hazard.
- Reset asserted mid-operation clears every pending bit. Any FPU write that arrives after reset deasserts is still applied normally; `f_wen` against a register with pend=0 is legal.

## Structure
- `fpu_types_pkg` holds:
  - `frm_t` enum: RNE=0, RTZ=1, RDN=2, RUP=3, RMM=4;
  - `fflags_t` packed struct {NV,DZ,OF,UF,NX};
  - the constants `FREG_ADDR_W`=5 and `FFLAGS_W`=5.
- Sub-module `fpu_scoreboard` holds the pending-bit vector, its set/clear priority and the busy outputs. The top level holds the array, bypass and CSR logic.

## Test plan
- **Reset values.** Reset, then write `f3`=0x3F800000 with all flags 0 and read `rs1`=3 → 0x3F800000. Every other register reads 0, `f_frm_out`=0 and `f_flags`=0.
- **Bypass.** `f_wen`=1, `f_rd`=7, `f_w_data`=0x40490FDB, with `f_rs2`=7 in the same cycle → `f_rs2_data`=0x40490FDB in that cycle. The next cycle reads the same value from the array.
- **Sticky flags.**
  - Write with NX=1, then write with DZ=1 → `f_flags`=5'b01001.
  - `f_flags_wen` with 5'b00000 plus a simultaneous FPU write with OF=1 → 5'b00100.
- **Pending bits.**
  - Issue rd=5 → `f_rs1_busy`=1 with `rs1`=5 the next cycle.
  - `f_wen` to rd=5 → busy=0 in that same cycle.
  - Simultaneous issue rd=5 and `f_wen` rd=5 → busy=1 the next cycle.
- **frm legality.** Write `frm`=3'b011 → `f_frm_out`=3. Write 3'b101 → `f_frm_out` stays 3. Write 3'b111 → stays 3.
- **Reset mid-flight.** Issue rd=9, assert `n_rst` → pend cleared. After release, `f_rs1_busy`=0 with `rs1`=9.

Source files
------------

// File: rtl/fpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpu_types_pkg
// Brief    : Shared types and constants for the F-extension register file.
// Revision : 1.0 - initial release
// ============================================================================
package fpu_types_pkg;

    localparam int FREG_ADDR_W = 5;
    localparam int FFLAGS_W    = 5;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } frm_t;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    // Encodings 101..111 are reserved and must never reach the frm register.
    function automatic logic frm_is_legal(input logic [2:0] value);
        return (value <= 3'd4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : fpu_scoreboard
// Brief    : Pending-write bit per FP register and RAW busy indications.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_scoreboard
    import fpu_types_pkg::*;
#(
    parameter int NREGS = 32
)
(
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   issue,
    input  logic [FREG_ADDR_W-1:0] issue_rd,
    input  logic                   wen,
    input  logic [FREG_ADDR_W-1:0] rd,
    input  logic [FREG_ADDR_W-1:0] rs1,
    input  logic [FREG_ADDR_W-1:0] rs2,
    output logic                   rs1_busy,
    output logic                   rs2_busy
);

    logic [NREGS-1:0] r_pend;
    logic             w_rs1_resolved;
    logic             w_rs2_resolved;

    for (genvar i = 0; i < NREGS; i++) begin : g_pend
        localparam logic [FREG_ADDR_W-1:0] c_idx = FREG_ADDR_W'(i);

        // Set is tested first: a fresh issue outlives a retiring write to the same register.
        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                r_pend[i] <= 1'b0;
            end else if (issue && (issue_rd == c_idx)) begin
                r_pend[i] <= 1'b1;
            end else if (wen && (rd == c_idx)) begin
                r_pend[i] <= 1'b0;
            end
        end
    end

    assign w_rs1_resolved = wen && (rd == rs1);
    assign w_rs2_resolved = wen && (rd == rs2);

    assign rs1_busy = r_pend[rs1] && !w_rs1_resolved;
    assign rs2_busy = r_pend[rs2] && !w_rs2_resolved;

endmodule
`default_nettype wire

// File: rtl/fpu_register_file.sv
`default_nettype none
// ============================================================================
// Module   : fpu_register_file
// Brief    : F-extension register file with write bypass, frm and sticky fflags.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_register_file
    import fpu_types_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int WIDTH = 32
)
(
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [FREG_ADDR_W-1:0] f_rs1,
    input  logic [FREG_ADDR_W-1:0] f_rs2,
    output logic [WIDTH-1:0]       f_rs1_data,
    output logic [WIDTH-1:0]       f_rs2_data,
    output logic                   f_rs1_busy,
    output logic                   f_rs2_busy,
    input  logic [FREG_ADDR_W-1:0] f_rd,
    input  logic                   f_wen,
    input  logic [WIDTH-1:0]       f_w_data,
    input  logic                   f_NV,
    input  logic                   f_DZ,
    input  logic                   f_OF,
    input  logic                   f_UF,
    input  logic                   f_NX,
    input  logic                   f_issue,
    input  logic [FREG_ADDR_W-1:0] f_issue_rd,
    input  logic                   f_frm_wen,
    input  logic [2:0]             f_frm_in,
    output logic [2:0]             f_frm_out,
    input  logic                   f_flags_wen,
    input  logic [FFLAGS_W-1:0]    f_flags_wdata,
    output logic [FFLAGS_W-1:0]    f_flags
);

    logic [WIDTH-1:0] r_regs [NREGS];
    frm_t             r_frm;
    fflags_t          r_flags;
    fflags_t          w_fpu_flags;
    fflags_t          w_flags_next;
    logic             w_rs1_bypass;
    logic             w_rs2_bypass;

    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        localparam logic [FREG_ADDR_W-1:0] c_idx = FREG_ADDR_W'(i);

        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                r_regs[i] <= '0;
            end else if (f_wen && (f_rd == c_idx)) begin
                r_regs[i] <= f_w_data;
            end
        end
    end

    assign w_rs1_bypass = f_wen && (f_rd == f_rs1);
    assign w_rs2_bypass = f_wen && (f_rd == f_rs2);

    assign f_rs1_data = w_rs1_bypass ? f_w_data : r_regs[f_rs1];
    assign f_rs2_data = w_rs2_bypass ? f_w_data : r_regs[f_rs2];

    fpu_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk      (clk),
        .n_rst    (n_rst),
        .issue    (f_issue),
        .issue_rd (f_issue_rd),
        .wen      (f_wen),
        .rd       (f_rd),
        .rs1      (f_rs1),
        .rs2      (f_rs2),
        .rs1_busy (f_rs1_busy),
        .rs2_busy (f_rs2_busy)
    );

    // A CSR write replaces the accumulated flags, but same-cycle FPU flags still land on top.
    always_comb begin
        w_fpu_flags  = '0;
        w_flags_next = r_flags;
        if (f_wen) begin
            w_fpu_flags = '{nv: f_NV, dz: f_DZ, of: f_OF, uf: f_UF, nx: f_NX};
        end
        if (f_flags_wen) begin
            w_flags_next = fflags_t'(f_flags_wdata);
        end
        w_flags_next = w_flags_next | w_fpu_flags;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_flags <= '0;
        end else begin
            r_flags <= w_flags_next;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_frm <= RNE;
        end else if (f_frm_wen && frm_is_legal(f_frm_in)) begin
            r_frm <= frm_t'(f_frm_in);
        end
    end

    assign f_frm_out = r_frm;
    assign f_flags   = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_fpu_register_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_register_file
// Brief    : Directed self-checking bench for fpu_register_file.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_register_file;

    logic        clk;
    logic        n_rst;
    logic [4:0]  f_rs1, f_rs2, f_rd, f_issue_rd;
    logic [31:0] f_rs1_data, f_rs2_data, f_w_data;
    logic        f_rs1_busy, f_rs2_busy;
    logic        f_wen, f_issue, f_frm_wen, f_flags_wen;
    logic        f_NV, f_DZ, f_OF, f_UF, f_NX;
    logic [2:0]  f_frm_in, f_frm_out;
    logic [4:0]  f_flags_wdata, f_flags;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    fpu_register_file #(
        .NREGS (32),
        .WIDTH (32)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .f_rs1         (f_rs1),
        .f_rs2         (f_rs2),
        .f_rs1_data    (f_rs1_data),
        .f_rs2_data    (f_rs2_data),
        .f_rs1_busy    (f_rs1_busy),
        .f_rs2_busy    (f_rs2_busy),
        .f_rd          (f_rd),
        .f_wen         (f_wen),
        .f_w_data      (f_w_data),
        .f_NV          (f_NV),
        .f_DZ          (f_DZ),
        .f_OF          (f_OF),
        .f_UF          (f_UF),
        .f_NX          (f_NX),
        .f_issue       (f_issue),
        .f_issue_rd    (f_issue_rd),
        .f_frm_wen     (f_frm_wen),
        .f_frm_in      (f_frm_in),
        .f_frm_out     (f_frm_out),
        .f_flags_wen   (f_flags_wen),
        .f_flags_wdata (f_flags_wdata),
        .f_flags       (f_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_val(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic idle();
        f_wen = 1'b0; f_issue = 1'b0; f_frm_wen = 1'b0; f_flags_wen = 1'b0;
        f_NV = 1'b0; f_DZ = 1'b0; f_OF = 1'b0; f_UF = 1'b0; f_NX = 1'b0;
    endtask

    // Inputs change 1 time unit after the rising edge; sampling happens 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_rst = 1'b0;
        f_rs1 = '0; f_rs2 = '0; f_rd = '0; f_issue_rd = '0;
        f_w_data = '0; f_frm_in = '0; f_flags_wdata = '0;
        idle();
        tick(); tick();
        n_rst = 1'b1;
        settle();

        // Reset state of CSRs
        expect_val("reset_frm", 32'd0);   check({29'd0, f_frm_out});
        expect_val("reset_flags", 32'd0); check({27'd0, f_flags});

        // Write f3 with no flags, then scan the whole file
        f_wen = 1'b1; f_rd = 5'd3; f_w_data = 32'h3F80_0000;
        tick();
        idle();
        for (int i = 0; i < 32; i++) begin
            f_rs1 = 5'(i);
            f_rs2 = 5'(31 - i);
            settle();
            expect_val($sformatf("reg_rs1_%0d", i), (i == 3) ? 32'h3F80_0000 : 32'd0);
            check(f_rs1_data);
            expect_val($sformatf("reg_rs2_%0d", 31 - i), (31 - i == 3) ? 32'h3F80_0000 : 32'd0);
            check(f_rs2_data);
        end
        expect_val("post_write_frm", 32'd0);   check({29'd0, f_frm_out});
        expect_val("post_write_flags", 32'd0); check({27'd0, f_flags});

        // Write-through bypass in the same cycle, array value afterwards
        f_wen = 1'b1; f_rd = 5'd7; f_w_data = 32'h4049_0FDB; f_rs2 = 5'd7; f_rs1 = 5'd3;
        settle();
        expect_val("bypass_rs2", 32'h4049_0FDB); check(f_rs2_data);
        expect_val("bypass_rs1_other", 32'h3F80_0000); check(f_rs1_data);
        tick();
        idle();
        settle();
        expect_val("array_after_bypass", 32'h4049_0FDB); check(f_rs2_data);

        // Sticky flags
        f_wen = 1'b1; f_rd = 5'd10; f_w_data = 32'h1; f_NX = 1'b1;
        tick();
        idle();
        f_wen = 1'b1; f_rd = 5'd11; f_w_data = 32'h2; f_DZ = 1'b1;
        tick();
        idle();
        expect_val("flags_sticky_or", 32'b01001); check({27'd0, f_flags});
        f_wen = 1'b1; f_rd = 5'd12; f_w_data = 32'h3;
        tick();
        idle();
        expect_val("flags_hold_clean_write", 32'b01001); check({27'd0, f_flags});
        f_NV = 1'b1; f_UF = 1'b1;
        tick();
        idle();
        expect_val("flags_ignored_without_wen", 32'b01001); check({27'd0, f_flags});
        f_flags_wen = 1'b1; f_flags_wdata = 5'b00000;
        f_wen = 1'b1; f_rd = 5'd13; f_w_data = 32'h4; f_OF = 1'b1;
        tick();
        idle();
        expect_val("flags_csr_plus_fpu", 32'b00100); check({27'd0, f_flags});

        // Pending bits
        f_issue = 1'b1; f_issue_rd = 5'd5; f_rs1 = 5'd5; f_rs2 = 5'd5;
        settle();
        expect_val("busy_same_cycle_issue", 32'd0); check({31'd0, f_rs1_busy});
        tick();
        idle();
        settle();
        expect_val("busy_rs1_after_issue", 32'd1); check({31'd0, f_rs1_busy});
        expect_val("busy_rs2_after_issue", 32'd1); check({31'd0, f_rs2_busy});
        f_rs2 = 5'd6;
        settle();
        expect_val("busy_rs2_other_reg", 32'd0); check({31'd0, f_rs2_busy});
        f_wen = 1'b1; f_rd = 5'd5; f_w_data = 32'h55;
        settle();
        expect_val("busy_resolved_by_wen", 32'd0); check({31'd0, f_rs1_busy});
        tick();
        idle();
        settle();
        expect_val("busy_cleared", 32'd0); check({31'd0, f_rs1_busy});
        f_issue = 1'b1; f_issue_rd = 5'd5; f_wen = 1'b1; f_rd = 5'd5; f_w_data = 32'h66;
        tick();
        idle();
        settle();
        expect_val("busy_set_wins", 32'd1); check({31'd0, f_rs1_busy});
        f_wen = 1'b1; f_rd = 5'd5; f_w_data = 32'h77;
        tick();
        idle();
        settle();
        expect_val("busy_final_clear", 32'd0); check({31'd0, f_rs1_busy});

        // frm legality
        f_frm_wen = 1'b1; f_frm_in = 3'b011;
        tick();
        idle();
        expect_val("frm_rup", 32'd3); check({29'd0, f_frm_out});
        f_frm_wen = 1'b1; f_frm_in = 3'b101;
        tick();
        idle();
        expect_val("frm_reserved_101", 32'd3); check({29'd0, f_frm_out});
        f_frm_wen = 1'b1; f_frm_in = 3'b111;
        tick();
        idle();
        expect_val("frm_reserved_111", 32'd3); check({29'd0, f_frm_out});
        f_frm_in = 3'b001;
        tick();
        expect_val("frm_no_wen", 32'd3); check({29'd0, f_frm_out});
        f_frm_wen = 1'b1; f_frm_in = 3'b100;
        tick();
        idle();
        expect_val("frm_rmm", 32'd4); check({29'd0, f_frm_out});

        // Reset mid-flight
        f_issue = 1'b1; f_issue_rd = 5'd9;
        tick();
        idle();
        f_rs1 = 5'd9; f_rs2 = 5'd3;
        settle();
        expect_val("busy_before_reset", 32'd1); check({31'd0, f_rs1_busy});
        #2;
        n_rst = 1'b0;
        settle();
        expect_val("async_reset_busy", 32'd0); check({31'd0, f_rs1_busy});
        expect_val("async_reset_reg", 32'd0);  check(f_rs2_data);
        expect_val("async_reset_frm", 32'd0);  check({29'd0, f_frm_out});
        expect_val("async_reset_flags", 32'd0); check({27'd0, f_flags});
        tick();
        n_rst = 1'b1;
        tick();
        expect_val("busy_after_release", 32'd0); check({31'd0, f_rs1_busy});
        f_wen = 1'b1; f_rd = 5'd9; f_w_data = 32'hC0DE_F00D; f_NV = 1'b1;
        tick();
        idle();
        settle();
        expect_val("late_write_reg", 32'hC0DE_F00D); check(f_rs1_data);
        expect_val("late_write_flags", 32'b10000);   check({27'd0, f_flags});
        expect_val("late_write_busy", 32'd0);        check({31'd0, f_rs1_busy});

        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
